// File: rtl/bit_field_extractor_if.sv
// ---------------------------------------------------------------------------
// bit_field_extractor_if
//   Request/response bundle for bit_field_extractor.
//   Request side : in_valid, in_ready, in_data, in_offset, in_len
//   Response side: out_valid, out_ready, out_data, out_err
//   Status       : busy
//   modport slave  - the extractor itself
//   modport master - the agent issuing requests and consuming results
// ---------------------------------------------------------------------------
interface bit_field_extractor_if #(
    parameter int DATA_W = 64,
    parameter int OUT_W  = 16,
    parameter int OFS_W  = $clog2(DATA_W) + 1,
    parameter int LEN_W  = $clog2(OUT_W) + 1
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [OFS_W-1:0]  in_offset;
    logic [LEN_W-1:0]  in_len;

    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_err;

    logic              busy;

    modport slave (
        input  in_valid, in_data, in_offset, in_len, out_ready,
        output in_ready, out_valid, out_data, out_err, busy
    );

    modport master (
        output in_valid, in_data, in_offset, in_len, out_ready,
        input  in_ready, out_valid, out_data, out_err, busy
    );

endinterface

// File: rtl/bit_field_extractor.sv
// ---------------------------------------------------------------------------
// bit_field_extractor
//   Runtime-programmable bit-field extractor: returns in_data[offset +: len]
//   LSB-aligned in an OUT_W-bit result. The right shift is done serially,
//   at most STEP bits per cycle, so the shifter stays small.
//
//   Ports
//     clk    in   rising-edge clock
//     reset  in   asynchronous, active-low reset
//     bus    slave modport of bit_field_extractor_if
//              in_valid/in_ready    request handshake
//              in_data/in_offset/in_len  request payload
//              out_valid/out_ready  result handshake
//              out_data/out_err     result and range-error flag
//              busy                 high whenever not idle
//
//   Configuration
//     FIELD_SIGN_EXT_EN  when defined, a field whose top bit (bit len-1) is
//                        set is sign-extended to OUT_W bits; otherwise the
//                        upper bits are zero.
// ---------------------------------------------------------------------------
module bit_field_extractor #(
    parameter int DATA_W = 64,
    parameter int OUT_W  = 16,
    parameter int STEP   = 8,
    parameter int OFS_W  = $clog2(DATA_W) + 1,
    parameter int LEN_W  = $clog2(OUT_W) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    bit_field_extractor_if.slave    bus
);

    // Offset+length sum is one bit wider than its widest operand so it
    // can never wrap.
    localparam int SUM_W = ((OFS_W > LEN_W) ? OFS_W : LEN_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_MASK,
        S_DONE
    } state_t;

    state_t             state_q, state_next;

    logic [DATA_W-1:0]  sh_q,  sh_next;
    logic [OFS_W-1:0]   rem_q, rem_next;
    logic [LEN_W-1:0]   len_q, len_next;
    logic               err_q, err_next;

    logic [OUT_W-1:0]   out_data_q,  out_data_next;
    logic               out_err_q,   out_err_next;
    logic               out_valid_q, out_valid_next;

    // Helpers shared by the FSM
    logic [OFS_W-1:0]   step;
    logic [SUM_W-1:0]   req_sum;
    logic               req_err;
    logic [LEN_W-1:0]   req_len;
    logic [OUT_W-1:0]   len_mask;
    logic               field_msb;
    logic [OUT_W-1:0]   field;

    // -----------------------------------------------------------------------
    // Datapath helpers
    // -----------------------------------------------------------------------
    always_comb begin
        // Shift amount for this cycle: min(STEP, remaining offset).
        step = (rem_q < OFS_W'(STEP)) ? rem_q : OFS_W'(STEP);

        // Range check and length clamp on the incoming request.
        req_sum = SUM_W'(bus.in_offset) + SUM_W'(bus.in_len);
        req_err = (req_sum > SUM_W'(DATA_W)) || (bus.in_len > LEN_W'(OUT_W));
        req_len = (bus.in_len > LEN_W'(OUT_W)) ? LEN_W'(OUT_W) : bus.in_len;

        // Mask of the low len_q bits, and the field's top bit (bit len_q-1).
        // len_q is already clamped to OUT_W, so both loops stay in range.
        len_mask  = '0;
        field_msb = 1'b0;
        for (int i = 0; i < OUT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
            if (int'(len_q) == i + 1) begin
                field_msb = sh_q[i];
            end
        end

        field = sh_q[OUT_W-1:0] & len_mask;
`ifdef FIELD_SIGN_EXT_EN
        // field_msb can only be set when len_q > 0.
        if (field_msb) begin
            field = field | ~len_mask;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Next-state and next-datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case leaves a value unassigned (no latches).
        state_next     = state_q;
        sh_next        = sh_q;
        rem_next       = rem_q;
        len_next       = len_q;
        err_next       = err_q;
        out_data_next  = out_data_q;
        out_err_next   = out_err_q;
        out_valid_next = out_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sh_next    = bus.in_data;
                    rem_next   = bus.in_offset;
                    len_next   = req_len;
                    err_next   = req_err;
                    state_next = (bus.in_offset != '0) ? S_SHIFT : S_MASK;
                end
            end

            S_SHIFT: begin
                // Offsets at or beyond DATA_W simply shift everything out.
                sh_next  = sh_q >> step;
                rem_next = rem_q - step;
                if (rem_q == step) begin
                    state_next = S_MASK;
                end
            end

            S_MASK: begin
                out_data_next  = field;
                out_err_next   = err_q;
                out_valid_next = 1'b1;
                state_next     = S_DONE;
            end

            S_DONE: begin
                // Result held until the consumer takes it.
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignments in clocked blocks, so every
            // register samples the pre-edge values regardless of order.
            state_q     <= S_IDLE;
            sh_q        <= '0;
            rem_q       <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_next;
            sh_q        <= sh_next;
            rem_q       <= rem_next;
            len_q       <= len_next;
            err_q       <= err_next;
            out_data_q  <= out_data_next;
            out_err_q   <= out_err_next;
            out_valid_q <= out_valid_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_bit_field_extractor.sv
// ---------------------------------------------------------------------------
// tb_bit_field_extractor
//   Self-checking bench for bit_field_extractor (DATA_W=64, OUT_W=16,
//   STEP=8). Directed cases followed by random requests, all compared with
//   a wide-shift reference model.
// ---------------------------------------------------------------------------
module tb_bit_field_extractor;

    localparam int DATA_W = 64;
    localparam int OUT_W  = 16;
    localparam int STEP   = 8;
    localparam int OFS_W  = $clog2(DATA_W) + 1;
    localparam int LEN_W  = $clog2(OUT_W) + 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bit_field_extractor_if #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .OFS_W(OFS_W), .LEN_W(LEN_W)
    ) bus ();

    bit_field_extractor #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .STEP(STEP),
        .OFS_W(OFS_W), .LEN_W(LEN_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: one wide shift of the zero-extended word, then mask.
    function automatic void model(input logic [63:0] d, input int off,
                                  input int len, output logic [15:0] f,
                                  output logic e, output int lat);
        logic [127:0] w;
        logic [15:0]  m;
        int           cl;
        w  = {64'd0, d} >> off;
        cl = (len > OUT_W) ? OUT_W : len;
        m  = 16'((32'd1 << cl) - 32'd1);
        f  = w[15:0] & m;
`ifdef FIELD_SIGN_EXT_EN
        if (cl > 0 && f[cl-1]) f = f | ~m;
`endif
        e   = ((off + len) > DATA_W) || (len > OUT_W);
        lat = (off + STEP - 1) / STEP + 1;
    endfunction

    // Issue one request (called #1 after an edge), wait for the result,
    // hold it for 'hold' cycles, then consume it.
    task automatic run_req(input string tag, input logic [63:0] d,
                           input int off, input int len, input int hold);
        logic [15:0] ef;
        logic        ee;
        int          lat;
        int          edges;
        model(d, off, len, ef, ee, lat);

        check({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_offset = OFS_W'(off);
        bus.in_len    = LEN_W'(len);
        @(posedge clk);
        #1;
        // Scramble the payload: nothing may be captured outside the accept.
        bus.in_valid  = 1'b0;
        bus.in_data   = {$urandom, $urandom};
        bus.in_offset = OFS_W'($urandom);
        bus.in_len    = LEN_W'($urandom);
        check({tag, ".busy"}, 64'(bus.busy), 64'd1);
        check({tag, ".in_ready_busy"}, 64'(bus.in_ready), 64'd0);

        edges = 0;
        while (!bus.out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({tag, ".latency"}, 64'(edges), 64'(lat));
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".out_data"}, 64'(bus.out_data), 64'(ef));
        check({tag, ".out_err"}, 64'(bus.out_err), 64'(ee));

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, ".hold_data"}, 64'(bus.out_data), 64'(ef));
            check({tag, ".hold_err"}, 64'(bus.out_err), 64'(ee));
            check({tag, ".hold_in_ready"}, 64'(bus.in_ready), 64'd0);
        end

        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".valid_drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, ".in_ready_after"}, 64'(bus.in_ready), 64'd1);
        check({tag, ".busy_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [15:0] exp3;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_offset = '0;
        bus.in_len    = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 64'(bus.out_valid), 64'd0);
        check("reset.out_data", 64'(bus.out_data), 64'd0);
        check("reset.out_err", 64'(bus.out_err), 64'd0);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.in_ready", 64'(bus.in_ready), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases with hand-derived expectations.
        run_req("t1", 64'h123, 4, 16, 0);
        check("t1.const_data", 64'h0012, 64'(16'h0012));
        run_req("t2", 64'h456 << 32, 36, 16, 0);
        run_req("t3", 64'hF0, 4, 4, 1);
        run_req("t4a", 64'hAB << 56, 56, 16, 0);
        run_req("t4b", 64'hFFFF_FFFF_FFFF_FFFF, 64, 8, 0);
        run_req("t5", 64'hDEAD_BEEF_CAFE_F00D, 12, 9, 3);
        run_req("len0", 64'hFFFF_FFFF_FFFF_FFFF, 64, 0, 0);
        run_req("len0err", 64'hFFFF_FFFF_FFFF_FFFF, 65, 0, 0);
        run_req("lenbig", 64'h0123_4567_89AB_CDEF, 0, 31, 0);
        run_req("ofsmax", 64'hFFFF_FFFF_FFFF_FFFF, 127, 16, 0);
        run_req("partial", 64'hFFFF_0000_0000_0000, 52, 16, 0);

        // Absolute spot check of test 3 against the documented result.
`ifdef FIELD_SIGN_EXT_EN
        exp3 = 16'hFFFF;
`else
        exp3 = 16'h000F;
`endif
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hF0;
        bus.in_offset = OFS_W'(4);
        bus.in_len    = LEN_W'(4);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t3.abs_valid", 64'(bus.out_valid), 64'd1);
        check("t3.abs_data", 64'(bus.out_data), 64'(exp3));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset while shifting: the request is dropped immediately.
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.in_offset = OFS_W'(40);
        bus.in_len    = LEN_W'(8);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6.busy_pre", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        check("t6.out_valid", 64'(bus.out_valid), 64'd0);
        check("t6.busy", 64'(bus.busy), 64'd0);
        check("t6.in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_req("t6.after", 64'h123, 4, 16, 0);

        // Random requests, offsets biased toward the interesting range.
        for (int n = 0; n < 150; n++) begin
            int off;
            int len;
            off = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127)
                                              : $urandom_range(0, 70);
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31)
                                              : $urandom_range(0, 16);
            run_req("rand", {$urandom, $urandom}, off, len,
                    $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
